// File: rtl/pulse_burst_pkg.sv
// Shared definitions for pulse_burst_gen: FSM state encoding and default counter width.
package pulse_burst_pkg;

  localparam int PULSE_BURST_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/pulse_burst_gen_rise_detect.sv
// Rising-edge detector for the trigger level; stays disarmed for the first cycle after
// reset so a level already high at reset release is not mistaken for a new edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q_r;
  logic armed_r;

  // Delayed copy of d plus the post-reset arm flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r     <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      q_r     <= d;
      armed_r <= 1'b1;
    end
  end

  assign rise = d & ~q_r & armed_r;

endmodule

// File: rtl/pulse_burst_gen.sv
// Configurable pulse-burst generator (IDLE/HIGH/LOW/DONE FSM).
// Define PULSE_BURST_GEN_RETRIGGER_EN to let a new trigger edge restart a running burst.
module pulse_burst_gen
  import pulse_burst_pkg::*;
#(
  parameter int CNT_W = PULSE_BURST_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_idx
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] num_lat_r;
  logic [CNT_W-1:0] high_lat_r;
  logic [CNT_W-1:0] low_lat_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] idx_r;
  logic [CNT_W-1:0] idx_inc_s;
  logic             start_s;
  logic             retrig_s;
  logic             in_burst_s;
  logic             accept_s;
  logic             cnt_zero_s;
  logic             last_s;
  logic             pulse_r, busy_r, done_r;
  logic             pulse_nxt_s, busy_nxt_s, done_nxt_s;

  // Phase counter reload value: counts down to zero, a zero length behaves as one cycle.
  function automatic logic [CNT_W-1:0] phase_last(input logic [CNT_W-1:0] len);
    if (len == CNT_ZERO) begin
      return CNT_ZERO;
    end else begin
      return len - CNT_ONE;
    end
  endfunction

  rise_detect u_rise_detect (
    .clk  (clk),
    .rst  (rst),
    .d    (trigger),
    .rise (start_s)
  );

`ifdef PULSE_BURST_GEN_RETRIGGER_EN
  assign retrig_s = start_s;
`else
  assign retrig_s = 1'b0;
`endif

  // Abort beats any start while a burst runs; outside IDLE a start counts only when retriggering.
  assign in_burst_s = (state_r == ST_HIGH) || (state_r == ST_LOW);
  assign accept_s   = start_s && ((state_r == ST_IDLE) || retrig_s) && !(abort && in_burst_s);
  assign idx_inc_s  = idx_r + CNT_ONE;
  assign cnt_zero_s = (cnt_r == CNT_ZERO);
  assign last_s     = (idx_inc_s == num_lat_r);

  // State and output flops; outputs are decoded from the next state so they come from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      pulse_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pulse_r <= pulse_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    if (accept_s) begin
      state_nxt_s = (num_pulses == CNT_ZERO) ? ST_DONE : ST_HIGH;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_HIGH: begin
          if (abort) begin
            state_nxt_s = ST_DONE;
          end else if (cnt_zero_s) begin
            state_nxt_s = last_s ? ST_DONE : ST_LOW;
          end else begin
            state_nxt_s = ST_HIGH;
          end
        end
        ST_LOW: begin
          if (abort) begin
            state_nxt_s = ST_DONE;
          end else if (cnt_zero_s) begin
            state_nxt_s = ST_HIGH;
          end else begin
            state_nxt_s = ST_LOW;
          end
        end
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output decode of the next state.
  always_comb begin
    pulse_nxt_s = 1'b0;
    busy_nxt_s  = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_IDLE: pulse_nxt_s = 1'b0;
      ST_HIGH: begin
        pulse_nxt_s = 1'b1;
        busy_nxt_s  = 1'b1;
      end
      ST_LOW:  busy_nxt_s = 1'b1;
      ST_DONE: done_nxt_s = 1'b1;
      default: pulse_nxt_s = 1'b0;
    endcase
  end

  // Config latches, phase counter and pulse index; an aborted phase never counts as a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_lat_r  <= CNT_ZERO;
      high_lat_r <= CNT_ZERO;
      low_lat_r  <= CNT_ZERO;
      cnt_r      <= CNT_ZERO;
      idx_r      <= CNT_ZERO;
    end else if (accept_s) begin
      num_lat_r  <= num_pulses;
      high_lat_r <= high_cycles;
      low_lat_r  <= low_cycles;
      cnt_r      <= phase_last(high_cycles);
      idx_r      <= CNT_ZERO;
    end else begin
      case (state_r)
        ST_HIGH: begin
          if (!abort && cnt_zero_s) begin
            idx_r <= idx_inc_s;
            cnt_r <= phase_last(low_lat_r);
          end else if (!abort) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_LOW: begin
          if (!abort && cnt_zero_s) begin
            cnt_r <= phase_last(high_lat_r);
          end else if (!abort) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign pulse     = pulse_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pulse_idx = idx_r;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Randomized self-checking bench for pulse_burst_gen against a burst-timeline reference model.
module tb_pulse_burst_gen;

  localparam int W = 8;
`ifdef PULSE_BURST_GEN_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         trigger;
  logic         abort;
  logic [W-1:0] num_pulses;
  logic [W-1:0] high_cycles;
  logic [W-1:0] low_cycles;
  logic         pulse;
  logic         busy;
  logic         done;
  logic [W-1:0] pulse_idx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct packed {
    logic         p;
    logic         b;
    logic         d;
    logic [W-1:0] idx;
  } obs_t;

  obs_t plan[$];
  obs_t cur;
  logic prev_trig;
  logic armed;

  pulse_burst_gen #(.CNT_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .abort       (abort),
    .num_pulses  (num_pulses),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .pulse       (pulse),
    .busy        (busy),
    .done        (done),
    .pulse_idx   (pulse_idx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic obs_t mk(input bit p, input bit b, input bit d, input int idx);
    obs_t o;
    o.p   = p;
    o.b   = b;
    o.d   = d;
    o.idx = idx[W-1:0];
    return o;
  endfunction

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Whole burst as a list of per-cycle outputs: n pulses of H cycles, gaps of L between them, then done.
  task automatic plan_burst(input int n, input int h, input int l);
    plan.delete();
    if (n == 0) begin
      plan.push_back(mk(1'b0, 1'b0, 1'b1, 0));
    end else begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < eff(h); k++) plan.push_back(mk(1'b1, 1'b1, 1'b0, i));
        if (i < n - 1)
          for (int k = 0; k < eff(l); k++) plan.push_back(mk(1'b0, 1'b1, 1'b0, i + 1));
      end
      plan.push_back(mk(1'b0, 1'b0, 1'b1, n));
    end
  endtask

  task automatic model_edge();
    logic start;
    if (rst) begin
      plan.delete();
      cur       = mk(1'b0, 1'b0, 1'b0, 0);
      prev_trig = 1'b0;
      armed     = 1'b0;
    end else begin
      start     = trigger && !prev_trig && armed;
      prev_trig = trigger;
      armed     = 1'b1;
      if (abort && cur.b) begin
        plan.delete();
        plan.push_back(mk(1'b0, 1'b0, 1'b1, int'(cur.idx)));
      end else if (start && ((!cur.b && !cur.d) || RETRIG)) begin
        plan_burst(int'(num_pulses), int'(high_cycles), int'(low_cycles));
      end
      if (plan.size() > 0) cur = plan.pop_front();
      else cur = mk(1'b0, 1'b0, 1'b0, int'(cur.idx));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_eq("pulse", pulse, cur.p);
    check_eq("busy", busy, cur.b);
    check_eq("done", done, cur.d);
    check_eq("pulse_idx", pulse_idx, cur.idx);
  endtask

  task automatic wait_low_idx(input int want, input int limit);
    int k;
    k = 0;
    while (!(cur.b && !cur.p && int'(cur.idx) == want) && k < limit) begin
      tick();
      k++;
    end
    check_eq("wait_low_timeout", (k < limit), 1'b1);
  endtask

  initial begin
    logic [7:0] pat;
    logic       any_busy;
    rst = 1'b1; trigger = 1'b0; abort = 1'b0;
    num_pulses = '0; high_cycles = '0; low_cycles = '0;
    repeat (3) tick();
    check_eq("reset_pulse_idx", pulse_idx, 0);
    rst = 1'b0;

    // num=3 high=2 low=1
    num_pulses = 8'd3; high_cycles = 8'd2; low_cycles = 8'd1;
    repeat (6) tick();
    trigger = 1'b1;
    tick();
    pat = 8'd0;
    for (int i = 0; i < 8; i++) begin
      pat = {pat[6:0], pulse};
      if (i < 7) tick();
    end
    check_eq("basic_pattern", pat, 8'b1101_1011);
    tick();
    check_eq("basic_done", done, 1'b1);
    check_eq("basic_idx", pulse_idx, 3);
    trigger = 1'b0;
    repeat (3) tick();

    // zero-pulse burst
    num_pulses = 8'd0;
    trigger = 1'b1;
    tick();
    check_eq("zero_done", done, 1'b1);
    check_eq("zero_busy", busy, 1'b0);
    trigger = 1'b0;
    repeat (3) tick();

    // zero-length phases
    num_pulses = 8'd2; high_cycles = 8'd0; low_cycles = 8'd0;
    trigger = 1'b1;
    tick();
    pat = 8'd0;
    for (int i = 0; i < 3; i++) begin
      pat = {pat[6:0], pulse};
      if (i < 2) tick();
    end
    check_eq("zero_len_pattern", pat, 8'b0000_0101);
    tick();
    check_eq("zero_len_done", done, 1'b1);
    trigger = 1'b0;
    repeat (3) tick();

    // abort in the second gap, then abort while idle
    num_pulses = 8'd5; high_cycles = 8'd2; low_cycles = 8'd3;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    wait_low_idx(2, 40);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_done", done, 1'b1);
    check_eq("abort_pulse", pulse, 1'b0);
    check_eq("abort_idx", pulse_idx, 2);
    abort = 1'b1;
    repeat (3) tick();
    abort = 1'b0;

    // reset while HIGH, trigger kept high across reset release
    num_pulses = 8'd4; high_cycles = 8'd3; low_cycles = 8'd2;
    trigger = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("rst_pulse", pulse, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_idx", pulse_idx, 0);
    rst = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any_busy = any_busy | busy;
    end
    check_eq("held_trigger_no_burst", any_busy, 1'b0);
    trigger = 1'b0;
    tick();

    // second edge during a running burst
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (8) tick();
    trigger = 1'b1;
    tick();
    if (RETRIG) check_eq("retrig_idx", pulse_idx, 0);
    else check_eq("retrig_ignored_idx", pulse_idx, 2);
    trigger = 1'b0;
    repeat (40) tick();

    // maximum pulse count
    num_pulses = 8'd255; high_cycles = 8'd0; low_cycles = 8'd0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (520) tick();
    check_eq("max_count_idx", pulse_idx, 255);

    // random traffic with configs changing every cycle
    for (int i = 0; i < 4000; i++) begin
      num_pulses  = W'($urandom_range(0, 5));
      high_cycles = W'($urandom_range(0, 3));
      low_cycles  = W'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) trigger = ~trigger;
      abort = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; abort = 1'b0; trigger = 1'b0;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulse_burst_gen.md
PULSE_BURST_GEN -- requirements
Module: pulse_burst_gen

Interface
REQ-001 Parameter: CNT_W, default 8, width of the burst-length and phase-length fields and counters.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 trigger  input  1  level start request from the countdown stage; a burst starts only on its rising edge.
REQ-005 abort  input  1  terminate the running burst.
REQ-006 num_pulses  input  CNT_W  number of pulses per burst; sampled at start.
REQ-007 high_cycles  input  CNT_W  pulse high-phase length in cycles; sampled at start.
REQ-008 low_cycles  input  CNT_W  gap length between pulses in cycles; sampled at start.
REQ-009 pulse  output  1  burst output; registered state decode, glitch-free.
REQ-010 busy  output  1  high in states HIGH and LOW.
REQ-011 done  output  1  single-cycle completion or abort strobe.
REQ-012 pulse_idx  output  CNT_W  number of pulses fully emitted in the current or last burst.

Function
REQ-013 The block SHALL register trigger as trigger_q; start = trigger & ~trigger_q.
REQ-014 The block SHALL implement states IDLE, HIGH, LOW and DONE.
REQ-015 IDLE: on start with num_pulses != 0, latch all three config inputs, clear pulse_idx, and go to HIGH; pulse rises the cycle after start (latency 1).
REQ-016 IDLE: on start with num_pulses == 0, go to DONE; pulse stays low.
REQ-017 A latched high_cycles or low_cycles value of 0 SHALL be treated as 1.
REQ-018 HIGH: pulse=1 for exactly the latched high_cycles cycles; on the last cycle increment pulse_idx.
REQ-019 HIGH exit: go to DONE if pulse_idx+1 == latched num_pulses; otherwise go to LOW. No trailing gap follows the final pulse.
REQ-020 LOW: pulse=0 for exactly the latched low_cycles cycles, then go to HIGH.
REQ-021 DONE: done=1 for one cycle, then go to IDLE; pulse_idx holds until the next start.
REQ-022 abort=1 in HIGH or LOW SHALL force DONE on the next cycle, with pulse=0 from that cycle; abort has priority over a same-cycle start or phase expiry.
REQ-023 abort in IDLE or DONE SHALL have no effect.
REQ-024 Config input changes during a burst SHALL not affect the running burst.
REQ-025 Counters SHALL be CNT_W bits; num_pulses = 2^CNT_W-1 SHALL complete without wrap.

Reset
REQ-026 rst SHALL force state=IDLE, pulse=0, busy=0, done=0, pulse_idx=0, trigger_q=0 and all latched config values to 0.
REQ-027 rst asserted mid-burst SHALL drop pulse on the following cycle with no done strobe.
REQ-028 If trigger is high when rst deasserts, it SHALL not start a burst until it falls and rises again; trigger_q is held at 0 during reset and captures trigger from the first cycle after reset.

Configuration
REQ-029 With macro PULSE_BURST_GEN_RETRIGGER_EN defined, a start in HIGH, LOW or DONE SHALL relatch the config inputs, clear pulse_idx and enter HIGH (or DONE if num_pulses == 0) on the next cycle; no done strobe is issued for the interrupted burst.
REQ-030 Without PULSE_BURST_GEN_RETRIGGER_EN, a start outside IDLE SHALL be ignored.
REQ-031 In both builds, abort SHALL take priority over retrigger.

Structure
REQ-032 Package pulse_burst_pkg SHALL hold the state enum type and the default CNT_W localparam.
REQ-033 The rising-edge detector SHALL be a sub-module rise_detect (ports clk, rst, d, rise).

Verification
REQ-034 Trigger rises at cycle 10 with num=3, high=2, low=1: pulse pattern 1,1,0,1,1,0,1,1 starts at cycle 11; done=1 at cycle 19; pulse_idx=3.
REQ-035 num=0, trigger rises: pulse never goes high, done=1 for one cycle, busy never goes high.
REQ-036 high=0, low=0, num=2: pulse pattern 1,0,1, then done.
REQ-037 abort during the second LOW of num=5: pulse stays 0, done fires the next cycle, pulse_idx=2.
REQ-038 Trigger held high through rst deassert and never toggled: no burst occurs; a second rising edge during a burst is ignored without the macro and restarts with pulse_idx=0 with the macro.
REQ-039 rst asserted in HIGH: the next cycle shows pulse=0, busy=0, done=0, pulse_idx=0.
